// File: rtl/sample_reader.sv
// Streams 32-bit words from a Wishbone-pipelined buffer out as bytes, little-endian.
// The read pointer chases the writer's pointer; a clear request rewinds it only at word boundaries.
module sample_reader #(
  parameter int unsigned PTR_W    = 12,
  parameter logic [31:0] BUF_BASE = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] avail_o,
  output logic [31:0]      mem_addr_o,
  output logic [3:0]       mem_sel_o,
  output logic             mem_we_o,
  output logic             mem_stb_o,
  input  logic             mem_stall_i,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_data_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] SHIFT    = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] rd_ptr;
  logic             clr_pend;
  logic [31:0]      shift_reg;
  logic [2:0]       byte_cnt;

  logic start;
  logic accept;
  logic handshake;
  logic last_byte;

  assign avail_o = wr_ptr_i - rd_ptr;

  // A clear arriving this very cycle also holds off a new read so it lands before the next word.
  assign start     = (state == IDLE) && enable_i && (avail_o != '0) && !clr_pend && !clear_i;
  assign accept    = (state == REQ) && !mem_stall_i;
  assign handshake = (state == SHIFT) && tx_ready_i;
  assign last_byte = handshake && (byte_cnt == 3'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (start)     state <= REQ;
        REQ:      if (accept)    state <= WAIT_ACK;
        WAIT_ACK: if (mem_ack_i) state <= SHIFT;
        SHIFT:    if (last_byte) state <= IDLE;
        default:                 state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr   <= '0;
      clr_pend <= 1'b0;
    end else if ((state == IDLE) && clr_pend) begin
      rd_ptr   <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (clear_i)   clr_pend <= 1'b1;
      if (last_byte) rd_ptr   <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if ((state == WAIT_ACK) && mem_ack_i) begin
      shift_reg <= mem_data_i;
      byte_cnt  <= 3'd4;
    end else if (handshake) begin
      shift_reg <= {8'h00, shift_reg[31:8]};
      byte_cnt  <= byte_cnt - 3'd1;
    end
  end

  assign rd_ptr_o   = rd_ptr;
  assign mem_addr_o = BUF_BASE + 32'({rd_ptr, 2'b00});
  assign mem_sel_o  = (state == REQ) ? 4'hF : '0;
  assign mem_we_o   = 1'b0;
  assign mem_stb_o  = (state == REQ);
  assign tx_valid_o = (state == SHIFT);
  assign tx_data_o  = shift_reg[7:0];

endmodule
